// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the WISC-SP22 fetch stage: opcode field layout,
// the HALT opcode, fetch FSM state encodings and a HALT-detect helper.
package fetch_stage_pkg;

  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

  typedef enum logic [1:0] {
    FS_FETCH  = 2'd0,
    FS_DROP   = 2'd1,
    FS_HALTED = 2'd2
  } fs_state_e;

  function automatic logic is_halt(input logic [OPC_W-1:0] opc);
    return (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO buffering fetched {instr, pc, pc+2} entries.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   push/wdata  write an entry (ignored when full or flushing)
//   pop         drop the head entry (ignored when empty or flushing)
//   flush       empty the FIFO; wins over push and pop
//   count       number of valid entries (0..DEPTH)
//   head        oldest entry, all zeros when empty
module fetch_stage_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_r;
  logic [PTR_W-1:0] rd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~flush & (cnt_r != CNT_W'(DEPTH));
  assign pop_ok_s  = pop  & ~flush & (cnt_r != CNT_W'(0));
  assign count     = cnt_r;
  assign head      = (cnt_r != CNT_W'(0)) ? mem_r[rd_r] : {WIDTH{1'b0}};

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_r  <= {PTR_W{1'b0}};
      rd_r  <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_r <= wr_r + PTR_W'(1);
      if (pop_ok_s)  rd_r <= rd_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through head when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_r] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC-SP22 instruction fetch stage. Owns the PC, issues one read at a time
// over a req/ack memory port, buffers fetched words in a FIFO and hands them
// to decode over valid/ready. Handles redirects and stops after HALT.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/imem_addr    read request, held with stable address until ack
//   imem_ack/imem_rdata   one-cycle read completion and data
//   redirect_valid/_pc    flush front of pipe and resume at redirect_pc
//   if_valid/dec_ready    head handshake to decode
//   if_instr/if_pc/if_pc_plus2/if_halt  head entry fields
//   err                   sticky: ack seen while no request raised
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus2,
  output logic               if_halt,
  output logic               err
);

  localparam int WIDTH = INSTR_W + 2 * ADDR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fs_state_e         state_r, state_n_s;
  logic [ADDR_W-1:0] pc_r, pc_n_s;
  logic              req_r, req_n_s;
  logic [ADDR_W-1:0] addr_r, addr_n_s;
  logic              err_r;
  logic              push_s, pop_s, flush_s;
  logic [CNT_W-1:0]  count_s, cnt_n_s;
  logic [WIDTH-1:0]  head_s;
  logic              if_valid_s;
  logic              holding_s, ack_ok_s;

  assign if_valid_s = (count_s != CNT_W'(0));
  // A raised request that is not completed this cycle must stay up untouched.
  assign holding_s  = req_r & ~imem_ack;
  assign ack_ok_s   = req_r & imem_ack;

  fetch_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata ({imem_rdata, pc_r, pc_r + ADDR_W'(2)}),
    .count (count_s),
    .head  (head_s)
  );

  // Next-state, FIFO control and next request computation.
  always_comb begin
    state_n_s = state_r;
    pc_n_s    = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    flush_s   = 1'b0;
    cnt_n_s   = count_s;
    req_n_s   = 1'b0;
    addr_n_s  = addr_r;
    if (redirect_valid) begin
      // Redirect wins over push, pop and halt detection.
      flush_s   = 1'b1;
      cnt_n_s   = CNT_W'(0);
      pc_n_s    = {redirect_pc[ADDR_W-1:1], 1'b0};
      state_n_s = holding_s ? FS_DROP : FS_FETCH;
    end else begin
      pop_s = if_valid_s & dec_ready;
      case (state_r)
        FS_FETCH: begin
          if (ack_ok_s) begin
            push_s    = 1'b1;
            pc_n_s    = pc_r + ADDR_W'(2);
            state_n_s = is_halt(imem_rdata[INSTR_W-1 -: OPC_W]) ? FS_HALTED : FS_FETCH;
          end else begin
            state_n_s = FS_FETCH;
          end
        end
        FS_DROP: begin
          // The stale ack is swallowed; pc already holds the redirect target.
          if (ack_ok_s) state_n_s = FS_FETCH;
          else          state_n_s = FS_DROP;
        end
        FS_HALTED: state_n_s = FS_HALTED;
        default:   state_n_s = FS_FETCH;
      endcase
      case ({push_s, pop_s})
        2'b10:   cnt_n_s = count_s + CNT_W'(1);
        2'b01:   cnt_n_s = count_s - CNT_W'(1);
        default: cnt_n_s = count_s;
      endcase
    end
    if (holding_s) begin
      req_n_s  = 1'b1;
      addr_n_s = addr_r;
    end else if ((state_n_s == FS_FETCH) && (cnt_n_s < CNT_W'(DEPTH))) begin
      req_n_s  = 1'b1;
      addr_n_s = pc_n_s;
    end else begin
      req_n_s  = 1'b0;
      addr_n_s = addr_r;
    end
  end

  // State, PC, request holding register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FS_FETCH;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      pc_r    <= pc_n_s;
      req_r   <= req_n_s;
      addr_r  <= addr_n_s;
      err_r   <= err_r | (imem_ack & ~req_r);
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign err         = err_r;
  assign if_valid    = if_valid_s;
  assign if_instr    = head_s[WIDTH-1 -: INSTR_W];
  assign if_pc       = head_s[2*ADDR_W-1 -: ADDR_W];
  assign if_pc_plus2 = head_s[ADDR_W-1:0];
  assign if_halt     = if_valid_s & is_halt(head_s[WIDTH-1 -: OPC_W]);

endmodule
